// File: rtl/core_pkg.sv
// Shared execute-stage types: engine selector and dispatch controller states.
package core_pkg;

  typedef enum logic [1:0] {
    EXEC_ALU = 2'd0,
    EXEC_MUL = 2'd1,
    EXEC_DIV = 2'd2
  } exec_engine_e;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MUL = 2'd1,
    WAIT_DIV = 2'd2,
    HOLD     = 2'd3
  } dispatch_state_e;

endpackage

// File: rtl/core_exec_dispatch_if.sv
// Issue-side and writeback-side handshakes of the execute dispatch controller.
interface core_exec_dispatch_if
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) ();

  logic              in_valid;
  logic              in_ready;
  exec_engine_e      in_engine;
  logic [2:0]        in_op;
  logic [XLEN-1:0]   in_a;
  logic [XLEN-1:0]   in_b;
  logic [XLEN-1:0]   alu_result;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_result;

  modport master (
    output in_valid, in_engine, in_op, in_a, in_b, alu_result, out_ready,
    input  in_ready, out_valid, out_result
  );

  modport slave (
    input  in_valid, in_engine, in_op, in_a, in_b, alu_result, out_ready,
    output in_ready, out_valid, out_result
  );

endinterface

// File: rtl/core_exec_dispatch.sv
// Execute-stage dispatch: routes one op to ALU/MUL/DIV, waits for the engine,
// and holds a registered result for writeback; flush kills in-flight work.
module core_exec_dispatch
  import core_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  core_exec_dispatch_if.slave io,
  output logic [2:0]      eng_op,
  output logic [XLEN-1:0] eng_a,
  output logic [XLEN-1:0] eng_b,
  output logic            mul_start,
  output logic            mul_kill,
  input  logic            mul_done,
  input  logic [XLEN-1:0] mul_result,
  output logic            div_start,
  output logic            div_kill,
  input  logic            div_done,
  input  logic [XLEN-1:0] div_result,
  output logic            busy
);

  dispatch_state_e state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            valid_q;
  logic            busy_q;
  logic            accept;

  assign eng_op        = io.in_op;
  assign eng_a         = io.in_a;
  assign eng_b         = io.in_b;
  assign io.out_valid  = valid_q;
  assign io.out_result = result_q;
  assign busy          = busy_q;

  // Handshake, engine strobes and next state / result selection.
  always_comb begin
    io.in_ready = !flush && ((state_q == IDLE) || ((state_q == HOLD) && io.out_ready));
    accept      = io.in_valid && io.in_ready;
    mul_start   = accept && (io.in_engine == EXEC_MUL);
    div_start   = accept && (io.in_engine == EXEC_DIV);
    mul_kill    = flush && (state_q == WAIT_MUL);
    div_kill    = flush && (state_q == WAIT_DIV);
    state_d     = state_q;
    result_d    = result_q;

    if (flush) begin
      state_d = IDLE;
    end else if (accept) begin
      case (io.in_engine)
        EXEC_ALU: begin
          state_d  = HOLD;
          result_d = io.alu_result;
        end
        EXEC_MUL: state_d = WAIT_MUL;
        EXEC_DIV: state_d = WAIT_DIV;
        default: begin
          state_d  = HOLD;
          result_d = '0;
        end
      endcase
    end else begin
      case (state_q)
        WAIT_MUL: if (mul_done) begin
          state_d  = HOLD;
          result_d = mul_result;
        end
        WAIT_DIV: if (div_done) begin
          state_d  = HOLD;
          result_d = div_result;
        end
        HOLD:     if (io.out_ready) state_d = IDLE;
        default:  state_d = state_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      valid_q  <= (state_d == HOLD);
      busy_q   <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_core_exec_dispatch.sv
// Directed bench for core_exec_dispatch with a transaction-level reference model.
module tb_core_exec_dispatch;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [2:0]  eng_op;
  logic [31:0] eng_a, eng_b;
  logic        mul_start, mul_kill, mul_done;
  logic [31:0] mul_result;
  logic        div_start, div_kill, div_done;
  logic [31:0] div_result;
  logic        busy;

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  core_exec_dispatch_if #(.XLEN(32)) bus ();

  core_exec_dispatch #(.XLEN(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .io(bus),
    .eng_op(eng_op), .eng_a(eng_a), .eng_b(eng_b),
    .mul_start(mul_start), .mul_kill(mul_kill), .mul_done(mul_done), .mul_result(mul_result),
    .div_start(div_start), .div_kill(div_kill), .div_done(div_done), .div_result(div_result),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: a held result (if any) and which engine, if any, owes us a result.
  bit          m_have = 1'b0;
  logic [31:0] m_res  = '0;
  int          m_pend = 0;   // 0 none, 1 mul, 2 div
  int unsigned delivered[$];

  function automatic bit exp_in_ready();
    return !flush && (m_pend == 0) && (!m_have || bus.out_ready);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    bit          acc, nh;
    logic [31:0] nr;
    int          np;
    if (!rst_n) begin
      m_have <= 1'b0;
      m_res  <= '0;
      m_pend <= 0;
    end else if (flush) begin
      m_have <= 1'b0;
      m_pend <= 0;
    end else begin
      acc = bus.in_valid && exp_in_ready();
      nh  = m_have;
      nr  = m_res;
      np  = m_pend;
      if (m_have && bus.out_ready) begin
        delivered.push_back(m_res);
        nh = 1'b0;
      end
      if (m_pend == 1 && mul_done) begin nh = 1'b1; nr = mul_result; np = 0; end
      if (m_pend == 2 && div_done) begin nh = 1'b1; nr = div_result; np = 0; end
      if (acc) begin
        if (bus.in_engine == EXEC_ALU)      begin nh = 1'b1; nr = bus.alu_result; end
        else if (bus.in_engine == EXEC_MUL) np = 1;
        else if (bus.in_engine == EXEC_DIV) np = 2;
        else                                begin nh = 1'b1; nr = '0; end
      end
      m_have <= nh;
      m_res  <= nr;
      m_pend <= np;
    end
  end

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin : compare
    bit ir, ms, ds;
    if (armed) begin
      ir = exp_in_ready();
      ms = bus.in_valid && ir && (bus.in_engine == EXEC_MUL);
      ds = bus.in_valid && ir && (bus.in_engine == EXEC_DIV);
      cmp("in_ready",  32'(bus.in_ready),  32'(ir));
      cmp("mul_start", 32'(mul_start),     32'(ms));
      cmp("div_start", 32'(div_start),     32'(ds));
      cmp("mul_kill",  32'(mul_kill),      32'(flush && m_pend == 1));
      cmp("div_kill",  32'(div_kill),      32'(flush && m_pend == 2));
      cmp("out_valid", 32'(bus.out_valid), 32'(m_have));
      cmp("busy",      32'(busy),          32'(m_have || m_pend != 0));
      if (m_have) cmp("out_result", bus.out_result, m_res);
      if (ms || ds) begin
        cmp("eng_a",  eng_a,         bus.in_a);
        cmp("eng_b",  eng_b,         bus.in_b);
        cmp("eng_op", 32'(eng_op),   32'(bus.in_op));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input exec_engine_e e, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] alu);
    bus.in_valid   = 1'b1;
    bus.in_engine  = e;
    bus.in_a       = a;
    bus.in_b       = b;
    bus.in_op      = 3'(a[2:0]);
    bus.alu_result = alu;
  endtask

  initial begin
    logic [31:0] alu_vals [3];
    logic [31:0] exp_log  [9];
    alu_vals = '{32'h11, 32'h22, 32'h33};
    exp_log  = '{32'h11, 32'h22, 32'h33, 32'd42, 32'h5, 32'h44, 32'h66, 32'h77, 32'h0};

    rst_n = 1'b0; flush = 1'b0;
    bus.in_valid = 1'b0; bus.in_engine = EXEC_ALU; bus.in_op = '0;
    bus.in_a = '0; bus.in_b = '0; bus.alu_result = '0; bus.out_ready = 1'b1;
    mul_done = 1'b0; mul_result = '0; div_done = 1'b0; div_result = '0;
    step(); step();
    armed = 1'b1;
    #2;
    cmp("rst_out_valid",  32'(bus.out_valid), 32'd0);
    cmp("rst_out_result", bus.out_result,     32'd0);
    cmp("rst_busy",       32'(busy),          32'd0);
    rst_n = 1'b1;
    step();

    // Back-to-back ALU ops, one per cycle.
    for (int i = 0; i < 3; i++) begin
      issue(EXEC_ALU, 32'(i), 32'd0, alu_vals[i]);
      step();
      #2;
      cmp("alu_b2b_valid",  32'(bus.out_valid), 32'd1);
      cmp("alu_b2b_result", bus.out_result,     alu_vals[i]);
    end
    bus.in_valid = 1'b0;
    step();

    // MUL 7*6 with a 4-cycle engine.
    issue(EXEC_MUL, 32'd7, 32'd6, 32'hFFFF);
    #2;
    cmp("mul_start_pulse", 32'(mul_start), 32'd1);
    cmp("mul_eng_a",       eng_a,          32'd7);
    cmp("mul_eng_b",       eng_b,          32'd6);
    step();
    bus.in_valid = 1'b0;
    #2;
    cmp("mul_wait_ready", 32'(bus.in_ready), 32'd0);
    step(); step(); step();
    mul_done = 1'b1; mul_result = 32'd42;
    step();
    mul_done = 1'b0;
    #2;
    cmp("mul_result", bus.out_result, 32'd42);
    step();

    // DIV result held under back-pressure.
    bus.out_ready = 1'b0;
    issue(EXEC_DIV, 32'd20, 32'd4, 32'h0);
    step();
    bus.in_valid = 1'b0;
    step();
    div_done = 1'b1; div_result = 32'h5;
    step();
    div_done = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #2;
      cmp("bp_valid",    32'(bus.out_valid), 32'd1);
      cmp("bp_result",   bus.out_result,     32'h5);
      cmp("bp_in_ready", 32'(bus.in_ready),  32'd0);
      step();
    end
    bus.out_ready = 1'b1;
    step();
    #2;
    cmp("bp_idle_busy", 32'(busy), 32'd0);

    // HOLD draining with a simultaneous DIV accept.
    bus.out_ready = 1'b0;
    issue(EXEC_ALU, 32'd1, 32'd2, 32'h44);
    step();
    bus.in_valid = 1'b0;
    step();
    bus.out_ready = 1'b1;
    issue(EXEC_DIV, 32'd9, 32'd3, 32'h0);
    #2;
    cmp("hold_acc_start", 32'(div_start), 32'd1);
    step();
    bus.in_valid = 1'b0;
    step();
    div_done = 1'b1; div_result = 32'h66;
    step();
    div_done = 1'b0;
    step();

    // Flush in WAIT_DIV coinciding with div_done.
    issue(EXEC_DIV, 32'd5, 32'd5, 32'h0);
    step();
    bus.in_valid = 1'b0;
    step();
    flush = 1'b1; div_done = 1'b1; div_result = 32'h9;
    #2;
    cmp("flush_div_kill", 32'(div_kill), 32'd1);
    step();
    flush = 1'b0; div_done = 1'b0;
    #2;
    cmp("flush_no_valid", 32'(bus.out_valid), 32'd0);
    step(); step();

    // Stray mul_done while waiting on the divider.
    issue(EXEC_DIV, 32'd6, 32'd2, 32'h0);
    step();
    bus.in_valid = 1'b0;
    mul_done = 1'b1; mul_result = 32'hBAD;
    step();
    mul_done = 1'b0;
    #2;
    cmp("stray_busy", 32'(busy), 32'd1);
    step();
    div_done = 1'b1; div_result = 32'h77;
    step();
    div_done = 1'b0;
    #2;
    cmp("stray_result", bus.out_result, 32'h77);
    step();

    // Unknown engine encoding yields a zero result.
    issue(exec_engine_e'(2'd3), 32'd1, 32'd1, 32'hDEAD);
    step();
    bus.in_valid = 1'b0;
    #2;
    cmp("bad_eng_result", bus.out_result, 32'd0);
    step();

    // Flush blocks an accept in IDLE.
    flush = 1'b1;
    issue(EXEC_MUL, 32'd2, 32'd2, 32'h0);
    #2;
    cmp("flush_blocks_start", 32'(mul_start), 32'd0);
    step();
    flush = 1'b0; bus.in_valid = 1'b0;
    step();

    // Flush discards a held result.
    bus.out_ready = 1'b0;
    issue(EXEC_ALU, 32'd0, 32'd0, 32'h55);
    step();
    bus.in_valid = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; bus.out_ready = 1'b1;
    #2;
    cmp("flush_hold_valid", 32'(bus.out_valid), 32'd0);
    step();

    // Reset while waiting on the multiplier.
    issue(EXEC_MUL, 32'd3, 32'd5, 32'h0);
    step();
    bus.in_valid = 1'b0;
    step();
    rst_n = 1'b0;
    #2;
    cmp("rst_mid_kill", 32'(mul_kill), 32'd0);
    step();
    rst_n = 1'b1;
    #2;
    cmp("rst_mid_valid",  32'(bus.out_valid), 32'd0);
    cmp("rst_mid_result", bus.out_result,     32'd0);
    cmp("rst_mid_busy",   32'(busy),          32'd0);
    step(); step();

    cmp("delivered_count", 32'(delivered.size()), 32'd9);
    for (int i = 0; i < 9; i++)
      if (i < delivered.size()) cmp("delivered_value", delivered[i], exp_log[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/core_exec_dispatch.md
Name: core_exec_dispatch

Overview:
Issue-side controller of the execute stage. It accepts one decoded operation at a time and routes it by exec_engine. It starts the multi-cycle MUL or DIV engine and waits for completion, or captures the single-cycle ALU result directly. It then presents one registered result with a valid/ready handshake to writeback. It also provides pipeline back-pressure and flush/kill of in-flight engine work.

Parameters:
XLEN, 32, operand/result width

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
flush  input  1  kill in-flight/held op (branch mispredict, trap)
in_valid  input  1  decoded op available
in_ready  output  1  op accepted this cycle when in_valid&in_ready
in_engine  input  core_pkg::exec_engine_e  target engine (EXEC_ALU/EXEC_MUL/EXEC_DIV)
in_op  input  3  funct3 sub-op, forwarded to engine
in_a  input  XLEN  operand A
in_b  input  XLEN  operand B
alu_result  input  XLEN  combinational ALU result for current in_a/in_b/in_op
eng_op  output  3  in_op passthrough, valid with a start pulse
eng_a  output  XLEN  in_a passthrough
eng_b  output  XLEN  in_b passthrough
mul_start  output  1  one-cycle start to multiplier
mul_kill  output  1  one-cycle abort to multiplier
mul_done  input  1  multiplier result valid (single-cycle pulse)
mul_result  input  XLEN  multiplier result
div_start  output  1  one-cycle start to divider
div_kill  output  1  one-cycle abort to divider
div_done  input  1  divider result valid (single-cycle pulse)
div_result  input  XLEN  divider result
out_valid  output  1  result available
out_ready  input  1  writeback accepts
out_result  output  XLEN  registered result
busy  output  1  state != IDLE

Behaviour:
- States: IDLE, WAIT_MUL, WAIT_DIV, HOLD.
- Reset (rst_n=0 at posedge): state=IDLE, out_valid=0, out_result=0, all start/kill=0, busy=0.
- in_ready = !flush && (IDLE || (HOLD && out_ready)). Throughput is one op/cycle for back-to-back ALU ops.
- Accept with EXEC_ALU: alu_result registered into out_result; next state HOLD. out_valid rises the cycle after accept (latency 1).
- Accept with EXEC_MUL or EXEC_DIV: the matching *_start is high combinationally in the accept cycle. eng_op/eng_a/eng_b carry in_op/in_a/in_b that cycle; engines latch at start. Next state is WAIT_MUL or WAIT_DIV.
- Accept with any other encoding: out_result=0, next state HOLD (latency 1, no engine started).
- WAIT_x: on x_done, register x_result and go to HOLD. The other engine's done is ignored. Done is sampled only in WAIT states, so engine latency must be at least 1 cycle after start.
- HOLD: out_valid=1 and out_result stable until out_ready.
  - out_ready with no new accept: go to IDLE.
  - out_ready with simultaneous accept: apply the accept transition directly.
- start is asserted only on accept; never in WAIT or HOLD without an accept.
- flush (any state): next state IDLE, out_valid drops next cycle, no accept this cycle.
  - In WAIT_MUL, mul_kill=1 this cycle; in WAIT_DIV, div_kill=1.
  - A done arriving in the same cycle as flush is discarded.
- Flush has priority over out_ready, done, and in_valid.
- rst_n low mid-operation: same as reset values. No kill pulse is issued; engines are reset by the same rst_n.
- All outputs except in_ready, start, kill, and eng_* are registered.

Decomposition:
- core_pkg: add dispatch_state_e {IDLE, WAIT_MUL, WAIT_DIV, HOLD}; reuse existing exec_engine_e.
- Single module, no sub-module. The result mux is internal, keyed on state.

Test Plan:
- ALU back-to-back: in_valid=1 for 3 cycles with alu_result 0x11, 0x22, 0x33, out_ready=1 -> out_valid high for 3 consecutive cycles starting 1 cycle later, results 0x11, 0x22, 0x33, in_ready constantly 1.
- MUL: accept in_a=7, in_b=6, in_engine=EXEC_MUL -> mul_start pulse with eng_a=7, eng_b=6; in_ready=0 until mul_done with mul_result=42 (4 cycles later); out_result=42 valid the next cycle.
- Back-pressure: DIV result 0x5 in HOLD with out_ready=0 for 3 cycles -> out_valid/out_result=0x5 held, in_ready=0; out_ready=1 -> accepted, returns to IDLE.
- Flush in WAIT_DIV: flush=1 same cycle as div_done (div_result=0x9) -> div_kill=1, next cycle IDLE, out_valid never asserts, 0x9 discarded.
- Stray done: mul_done pulse in WAIT_DIV -> ignored, state stays WAIT_DIV until div_done.
- Reset mid-WAIT_MUL: rst_n=0 one cycle -> state IDLE, out_valid=0, out_result=0, busy=0, no start/kill pulse.
